// File: rtl/if_id_queue_pkg.sv
// ----------------------------------------------------------------------------
// if_id_queue_pkg
// Purpose : Shared defines for the fetch/decode instruction queue.
// Contents: bus widths, zero word and reset polarity used across the slice.
// ----------------------------------------------------------------------------
package if_id_queue_pkg;

    localparam int unsigned InstAddrBus = 32;            // PC width
    localparam int unsigned InstBus     = 32;            // instruction width
    localparam logic [31:0] ZeroWord    = 32'h0000_0000; // NOP bubble word
    localparam logic        RstEnable   = 1'b1;          // rst is active-high

endpackage

// File: rtl/ifq_storage.sv
// ----------------------------------------------------------------------------
// ifq_storage
// Purpose : DEPTH x WIDTH register array, one synchronous write port and one
//           asynchronous read port. Data is not reset.
// Ports   : clk      - clock, rising edge
//           i_we     - write enable
//           i_waddr  - write address
//           i_wdata  - write data
//           i_raddr  - read address
//           o_rdata  - read data (combinational from i_raddr)
// ----------------------------------------------------------------------------
module ifq_storage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
// Purpose : Instruction buffer between fetch and decode. Holds up to DEPTH
//           {pc, inst} pairs in program order with valid/ready on both sides.
//           flush empties the queue in one cycle; an empty queue presents an
//           all-zero bubble to decode.
// Ports   : clk, rst            - clock and synchronous active-high reset
//           rdy                 - global clock-enable, freezes all state when low
//           in_valid/in_ready   - fetch handshake, in_pc/in_inst payload
//           flush               - discard all entries (redirect)
//           out_valid/out_ready - decode handshake, out_pc/out_inst head entry
//           count               - occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned XLEN  = InstAddrBus,
    parameter int unsigned ILEN  = InstBus,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [ILEN-1:0]            in_inst,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [ILEN-1:0]            out_inst,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = XLEN + ILEN;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [DW-1:0] w_rdata;

    // Handshake flags come from count alone, so there is no combinational path
    // from in_valid/out_ready back to in_ready/out_valid.
    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);

    assign w_push = in_valid & in_ready & rdy & ~flush;
    assign w_pop  = out_valid & out_ready & rdy & ~flush;

    // Pointers are AW bits wide and DEPTH is a power of two, so +1 wraps
    // naturally; full/empty is told apart by count, not pointer equality.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    ifq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (DW),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata ({in_pc, in_inst}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Empty queue shows a NOP bubble instead of stale storage.
    assign out_pc   = out_valid ? w_rdata[DW-1:ILEN] : '0;
    assign out_inst = out_valid ? w_rdata[ILEN-1:0]  : '0;
    assign count    = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            rdy;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [ILEN-1:0] in_inst;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_inst;
    logic [CW-1:0]   count;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of {pc, inst} in program order.
    logic [XLEN+ILEN-1:0] model_q[$];

    always #5 clk = ~clk;

    if_id_queue #(
        .XLEN  (XLEN),
        .ILEN  (ILEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned n;
        logic [XLEN+ILEN-1:0] head;
        n    = model_q.size();
        head = (n != 0) ? model_q[0] : '0;
        chk({tag, ".count"},     64'(count),     64'(n));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(n != 0));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(n < DEPTH));
        chk({tag, ".out_pc"},    64'(out_pc),    64'(head[XLEN+ILEN-1:ILEN]));
        chk({tag, ".out_inst"},  64'(out_inst),  64'(head[ILEN-1:0]));
    endtask

    // One clock edge: update the model from the inputs seen at the edge, then
    // step 1 time unit past it so outputs are sampled away from the edge.
    task automatic tick();
        int unsigned n;
        bit push, pop;
        @(posedge clk);
        n    = model_q.size();
        push = in_valid && (n < DEPTH) && rdy && !flush;
        pop  = (n != 0) && out_ready && rdy && !flush;
        if (rst || (rdy && flush)) begin
            model_q.delete();
        end else begin
            if (pop)  void'(model_q.pop_front());
            if (push) model_q.push_back({in_pc, in_inst});
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic ordy,
                         input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = $urandom;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic drain();
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) tick();
    endtask

    initial begin
        logic [XLEN-1:0] exp_head;
        logic [CW-1:0]   held_count;
        logic [XLEN-1:0] held_pc;
        logic [ILEN-1:0] held_inst;

        rst = 1'b1;
        rdy = 1'b1;
        drive(1'b1, 32'h0000_0abc, 1'b0, 1'b0);

        // Reset held for two cycles while fetch is pushing.
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        check_all("reset");
        chk("reset.in_ready", 64'(in_ready), 64'(1));

        // Fill to DEPTH with decode stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, XLEN'(i * 4), 1'b0, 1'b0);
            tick();
            check_all("fill");
        end
        chk("fill.count_full", 64'(count), 64'(4));
        chk("fill.in_ready_low", 64'(in_ready), 64'(0));
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        chk("fill.fifth_rejected", 64'(count), 64'(4));
        chk("fill.head_pc", 64'(out_pc), 64'(0));
        check_all("fill5");

        // Stream with two entries resident.
        drain();
        check_all("drained");
        drive(1'b1, 32'h1000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h1004, 1'b0, 1'b0);
        tick();
        exp_head = 32'h1000;
        chk("stream.start_pc", 64'(out_pc), 64'(exp_head));
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, XLEN'(32'h1008 + i * 4), 1'b1, 1'b0);
            tick();
            exp_head += 4;
            chk("stream.count", 64'(count), 64'(2));
            chk("stream.pc_seq", 64'(out_pc), 64'(exp_head));
            check_all("stream");
        end

        // Flush colliding with a push and a pop.
        drive(1'b1, 32'h2000, 1'b0, 1'b0);
        tick();
        chk("flush.pre_count", 64'(count), 64'(3));
        drive(1'b1, 32'h100, 1'b1, 1'b1);
        tick();
        chk("flush.count", 64'(count), 64'(0));
        chk("flush.out_inst", 64'(out_inst), 64'(0));
        check_all("flush");
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("flush.after_pc", 64'(out_pc), 64'(32'h200));
        check_all("after_flush");

        // Freeze with rdy low while inputs toggle.
        drive(1'b1, 32'h204, 1'b0, 1'b0);
        tick();
        held_count = count;
        held_pc    = model_q[0][XLEN+ILEN-1:ILEN];
        held_inst  = model_q[0][ILEN-1:0];
        chk("freeze.pre_count", 64'(held_count), 64'(2));
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 1'(i[0]));
            tick();
            chk("freeze.count", 64'(count), 64'(2));
            chk("freeze.pc", 64'(out_pc), 64'(held_pc));
            chk("freeze.inst", 64'(out_inst), 64'(held_inst));
        end
        rdy = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        chk("resume.pc", 64'(out_pc), 64'(32'h204));
        check_all("resume");

        // Minimum latency from empty.
        drain();
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        #1;
        chk("latency.n_valid", 64'(out_valid), 64'(0));
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("latency.n1_valid", 64'(out_valid), 64'(1));
        chk("latency.n1_pc", 64'(out_pc), 64'(32'h40));

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            drive(1'($urandom), $urandom, 1'($urandom),
                  ($urandom_range(0, 19) == 0));
            tick();
            check_all("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
